// File: rtl/reg_stream_fifo.sv
// reg_stream_fifo: register-file slave that captures a 32-bit valid/ready
// stream into a FIFO. Software drains the FIFO through a pop-on-read DATA
// register. The block also provides control, status, threshold, word
// counter, scratch, ID and a maskable interrupt.
// Handshake: a stream word is transferred on a rising clk edge where
// i_valid and o_ready are both high. o_ready is combinational and never
// depends on i_valid.
module reg_stream_fifo #(
    parameter int          DEPTH        = 16,
    parameter int          R_ADDR_WIDTH = 3,
    parameter logic [31:0] ID_VALUE     = 32'h5F1F0001
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_rd,
    input  logic [R_ADDR_WIDTH-1:0] i_rreg,
    input  logic                    i_wr,
    input  logic [R_ADDR_WIDTH-1:0] i_wreg,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata,
    input  logic                    i_valid,
    input  logic [31:0]             i_data,
    output logic                    o_ready,
    output logic                    o_irq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ctrl_en_q, ctrl_irqen_q;
    logic [2:0]    flags_q, flags_d, flags_set;
    logic [15:0]   thresh_q;
    logic [31:0]   count_q, count_d;
    logic [31:0]   scratch_q;
    logic [31:0]   rdata_q, rd_val;
    logic          irq_q;

    logic wr_ctrl, wr_flags, wr_thresh, wr_count, wr_scratch;
    logic rd_data, empty, full, flush_now, push, pop;

    assign wr_ctrl    = i_wr && (i_wreg == R_ADDR_WIDTH'(0));
    assign wr_flags   = i_wr && (i_wreg == R_ADDR_WIDTH'(3));
    assign wr_thresh  = i_wr && (i_wreg == R_ADDR_WIDTH'(4));
    assign wr_count   = i_wr && (i_wreg == R_ADDR_WIDTH'(5));
    assign wr_scratch = i_wr && (i_wreg == R_ADDR_WIDTH'(6));
    assign rd_data    = i_rd && (i_rreg == R_ADDR_WIDTH'(2));

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign flush_now = wr_ctrl && i_wdata[1];
    assign o_ready   = ctrl_en_q && !full && !flush_now;
    assign push      = i_valid && o_ready;
    // A DATA read on an empty FIFO is an underflow, not a pop, even if a
    // word is pushed in the same cycle.
    assign pop       = rd_data && !empty;

    assign o_rdata = rdata_q;
    assign o_irq   = irq_q;

    // Next-state level: flush dominates, simultaneous push/pop cancel
    always_comb begin
        level_d = level_q;
        if (flush_now) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Flag set sources, W1C clear, set wins over clear in the same cycle
    always_comb begin
        flags_set[0] = (thresh_q != 16'd0) && (16'(level_q) >= thresh_q);
        flags_set[1] = i_valid && ctrl_en_q && full;
        flags_set[2] = rd_data && empty;
        flags_d      = (flags_q & ~(wr_flags ? i_wdata[2:0] : 3'b000)) | flags_set;
    end

    // Word counter: any write clears it, the same-cycle push still counts
    always_comb begin
        count_d = wr_count ? {31'd0, push} : count_q + {31'd0, push};
    end

    // Read mux over the current (pre-edge) register state
    always_comb begin
        rd_val = 32'd0;
        case (i_rreg)
            R_ADDR_WIDTH'(0): rd_val = {29'd0, ctrl_irqen_q, 1'b0, ctrl_en_q};
            R_ADDR_WIDTH'(1): rd_val = {14'd0, full, empty, 16'(level_q)};
            R_ADDR_WIDTH'(2): rd_val = empty ? 32'd0 : mem_q[rd_ptr_q];
            R_ADDR_WIDTH'(3): rd_val = {29'd0, flags_q};
            R_ADDR_WIDTH'(4): rd_val = {16'd0, thresh_q};
            R_ADDR_WIDTH'(5): rd_val = count_q;
            R_ADDR_WIDTH'(6): rd_val = scratch_q;
            R_ADDR_WIDTH'(7): rd_val = ID_VALUE;
            default:          rd_val = 32'd0;
        endcase
    end

    // FIFO storage: contents need no reset, level/pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // FIFO pointers and level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (flush_now) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Software-visible registers, read data and interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_en_q    <= 1'b0;
            ctrl_irqen_q <= 1'b0;
            flags_q      <= 3'b000;
            thresh_q     <= 16'd0;
            count_q      <= 32'd0;
            scratch_q    <= 32'd0;
            rdata_q      <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q    <= i_wdata[0];
                ctrl_irqen_q <= i_wdata[2];
            end
            if (wr_thresh)  thresh_q  <= i_wdata[15:0];
            if (wr_scratch) scratch_q <= i_wdata;
            if (i_rd)       rdata_q   <= rd_val;
            flags_q <= flags_d;
            count_q <= count_d;
            irq_q   <= ctrl_irqen_q && (flags_q != 3'b000);
        end
    end

endmodule

// File: tb/tb_reg_stream_fifo.sv
// Testbench for reg_stream_fifo: directed scenarios followed by random
// traffic, checked against a queue-based behavioural model.
module tb_reg_stream_fifo;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] ID    = 32'h5F1F0001;

    logic          clk;
    logic          rstn;
    logic          i_rd;
    logic [AW-1:0] i_rreg;
    logic          i_wr;
    logic [AW-1:0] i_wreg;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          i_valid;
    logic [31:0]   i_data;
    logic          o_ready;
    logic          o_irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    // behavioural model state
    logic [31:0] m_fifo[$];
    logic        m_en, m_irqen, m_irq;
    logic [2:0]  m_flags;
    logic [15:0] m_thresh;
    logic [31:0] m_count, m_scratch;

    reg_stream_fifo #(.DEPTH(DEPTH), .R_ADDR_WIDTH(AW), .ID_VALUE(ID)) dut (
        .clk(clk), .rstn(rstn),
        .i_rd(i_rd), .i_rreg(i_rreg),
        .i_wr(i_wr), .i_wreg(i_wreg), .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_irq(o_irq)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_en = 0; m_irqen = 0; m_irq = 0; m_flags = 0;
        m_thresh = 0; m_count = 0; m_scratch = 0;
    endtask

    function automatic logic [31:0] model_reg(input logic [AW-1:0] r);
        int sz = m_fifo.size();
        case (r)
            0: return {29'd0, m_irqen, 1'b0, m_en};
            1: return {14'd0, sz == DEPTH, sz == 0, 16'(sz)};
            2: return (sz == 0) ? 32'd0 : m_fifo[0];
            3: return {29'd0, m_flags};
            4: return {16'd0, m_thresh};
            5: return m_count;
            6: return m_scratch;
            7: return ID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_ready();
        bit flush = i_wr && (i_wreg == 0) && i_wdata[1];
        return m_en && (m_fifo.size() < DEPTH) && !flush;
    endfunction

    // advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        int   sz    = m_fifo.size();
        bit   flush = i_wr && (i_wreg == 0) && i_wdata[1];
        bit   push  = i_valid && model_ready();
        bit   rdd   = i_rd && (i_rreg == 2);
        logic [2:0] set;
        if (i_rd) exp_q.push_back(model_reg(i_rreg));
        m_irq = m_irqen && (m_flags != 0);
        set[0] = (m_thresh != 0) && (sz >= int'(m_thresh));
        set[1] = i_valid && m_en && (sz == DEPTH);
        set[2] = rdd && (sz == 0);
        if (i_wr && i_wreg == 3) m_flags = m_flags & ~i_wdata[2:0];
        m_flags = m_flags | set;
        if (rdd && sz != 0) void'(m_fifo.pop_front());
        if (flush) m_fifo.delete();
        if (push) m_fifo.push_back(i_data);
        if (i_wr && i_wreg == 5) m_count = push ? 32'd1 : 32'd0;
        else if (push) m_count = m_count + 1;
        if (i_wr && i_wreg == 0) begin m_en = i_wdata[0]; m_irqen = i_wdata[2]; end
        if (i_wr && i_wreg == 4) m_thresh = i_wdata[15:0];
        if (i_wr && i_wreg == 6) m_scratch = i_wdata;
    endtask

    // driver: one clock cycle with the given inputs, entered and left at negedge
    task automatic do_cycle(input bit rd, input int rreg, input bit wr, input int wreg,
                            input logic [31:0] wdata, input bit valid, input logic [31:0] data);
        i_rd = rd; i_rreg = AW'(rreg);
        i_wr = wr; i_wreg = AW'(wreg); i_wdata = wdata;
        i_valid = valid; i_data = data;
        #1;
        check("o_ready", {31'd0, o_ready}, {31'd0, model_ready()});
        model_step();
        @(posedge clk);
        #1;
        check("o_irq", {31'd0, o_irq}, {31'd0, m_irq});
        @(negedge clk);
        i_rd = 0; i_wr = 0; i_valid = 0;
    endtask

    task automatic rd_reg(input int r);
        do_cycle(1, r, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_reg(input int r, input logic [31:0] d);
        do_cycle(0, 0, 1, r, d, 0, 0);
    endtask

    task automatic push_word(input logic [31:0] d);
        do_cycle(0, 0, 0, 0, 0, 1, d);
    endtask

    // monitor: compares read data one edge after each accepted read strobe
    always @(posedge clk) begin
        if (rstn && i_rd) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got 0x%08h with no expected value", o_rdata);
            end else begin
                check("o_rdata", o_rdata, exp_q.pop_front());
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 0; i_rd = 0; i_rreg = 0; i_wr = 0; i_wreg = 0;
        i_wdata = 0; i_valid = 0; i_data = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_irq", {31'd0, o_irq}, 32'd0);
        check("reset_ready", {31'd0, o_ready}, 32'd0);
        rstn = 1;
        @(negedge clk);

        // reset register values, stream blocked while disabled
        rd_reg(7); rd_reg(1); rd_reg(0);
        push_word(32'h1234);
        rd_reg(1);
        rd_reg(9); rd_reg(15);   // unmapped indices
        wr_reg(9, 32'hFFFF_FFFF); // ignored
        wr_reg(7, 32'h0);         // read-only, ignored
        rd_reg(7);

        // basic ordering
        wr_reg(0, 32'h1);
        push_word(32'hA0); push_word(32'hA1); push_word(32'hA2);
        rd_reg(2); rd_reg(2); rd_reg(2);
        rd_reg(1); rd_reg(5);

        // fill to full with overflow, set wins over W1C
        wr_reg(5, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) push_word(32'hB000 + i);
        rd_reg(1); rd_reg(3); rd_reg(5);
        do_cycle(0, 0, 1, 3, 32'h2, 1, 32'hDEAD);
        do_cycle(1, 3, 0, 0, 0, 1, 32'hDEAD);
        // pop from full frees a slot
        rd_reg(2); rd_reg(1);
        wr_reg(0, 32'h3);   // flush, stay enabled
        wr_reg(3, 32'h7);
        rd_reg(3); rd_reg(1);

        // threshold and interrupt
        wr_reg(4, 32'h4);
        wr_reg(0, 32'h5);
        for (int i = 0; i < 4; i++) push_word(32'hC0 + i);
        rd_reg(3);
        do_cycle(0, 0, 0, 0, 0, 0, 0);
        rd_reg(2);
        wr_reg(3, 32'h1);
        do_cycle(0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0);
        rd_reg(3);

        // underflow, then push+pop at level 2
        wr_reg(0, 32'h3);
        wr_reg(4, 32'h0);
        wr_reg(3, 32'h7);
        rd_reg(2);
        rd_reg(3);
        push_word(32'hD0); push_word(32'hD1);
        do_cycle(1, 2, 0, 0, 0, 1, 32'hD2);
        rd_reg(1);
        rd_reg(2); rd_reg(2); rd_reg(2);
        // underflow with a same-cycle push stores the word
        do_cycle(1, 2, 0, 0, 0, 1, 32'hD3);
        rd_reg(1); rd_reg(2);

        // flush while a word is offered, DATA read in the flush cycle
        wr_reg(3, 32'h7);
        for (int i = 0; i < 5; i++) push_word(32'hE0 + i);
        do_cycle(1, 2, 1, 0, 32'h3, 1, 32'hEEEE);
        rd_reg(1);
        push_word(32'hF0);
        rd_reg(1); rd_reg(2);

        // COUNT clear coincident with a push
        do_cycle(0, 0, 1, 5, 32'h0, 1, 32'hF1);
        rd_reg(5);
        wr_reg(6, 32'hCAFE_F00D); rd_reg(6);

        // random traffic
        wr_reg(4, 32'h6);
        wr_reg(0, 32'h5);
        for (int n = 0; n < 600; n++) begin
            bit   rd, wr, vld;
            int   rr, wrg;
            logic [31:0] wd;
            rd  = ($urandom_range(0, 2) == 0);
            rr  = ($urandom_range(0, 1) == 0) ? 2 : $urandom_range(0, 9);
            wr  = ($urandom_range(0, 7) == 0);
            wrg = $urandom_range(0, 9);
            wd  = $urandom;
            if (wrg == 0 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
            if (wrg == 0) wd[0] = ($urandom_range(0, 4) != 0);
            if (wrg == 4) wd = {16'd0, 16'($urandom_range(0, DEPTH))};
            vld = ($urandom_range(0, 1) == 0);
            do_cycle(rd, rr, wr, wrg, wd, vld, $urandom);
        end
        rd_reg(1); rd_reg(3); rd_reg(5);

        // asynchronous reset mid-operation
        rd_reg(7);
        wr_reg(0, 32'h5);
        push_word(32'h77);
        rstn = 0;
        #1;
        model_reset();
        check("midrst_rdata", o_rdata, 32'd0);
        check("midrst_irq", {31'd0, o_irq}, 32'd0);
        check("midrst_ready", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        rd_reg(1); rd_reg(0); rd_reg(5);
        do_cycle(0, 0, 0, 0, 0, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
